// File: rtl/regs_dump_ctrl.sv
// Debug dump sequencer: halts the pipeline, waits a drain period, snapshots the
// flattened register bank and streams it out MSB-first per register as bytes.
module regs_dump_ctrl #(
    parameter int REGISTERS_BANK_SIZE = 32,
    parameter int BUS_SIZE            = 32,
    parameter int DRAIN_CYCLES        = 4
) (
    input  logic                                    i_clk,
    input  logic                                    i_reset,
    input  logic                                    i_start,
    input  logic [REGISTERS_BANK_SIZE*BUS_SIZE-1:0] i_bus_debug,
    input  logic                                    i_tx_ready,
    output logic                                    o_tx_valid,
    output logic [7:0]                              o_tx_data,
    output logic                                    o_halt,
    output logic                                    o_busy,
    output logic                                    o_done
);

    localparam int TOTAL  = REGISTERS_BANK_SIZE * BUS_SIZE;
    localparam int NBYTES = TOTAL / 8;
    localparam int BPR    = BUS_SIZE / 8;
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int RW     = (REGISTERS_BANK_SIZE > 1) ? $clog2(REGISTERS_BANK_SIZE) : 1;
    localparam int SW     = (BPR > 1) ? $clog2(BPR) : 1;
    localparam int DW     = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRAIN = 3'd1,
        SNAP  = 3'd2,
        SEND  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state, state_n;
    logic [DW-1:0]    drain_cnt, drain_cnt_n;
    logic [CW-1:0]    byte_cnt, byte_cnt_n;
    logic [RW-1:0]    reg_idx, reg_idx_n;
    logic [SW-1:0]    sub_idx, sub_idx_n;
    logic [TOTAL-1:0] shadow;
    logic             capture;

    logic             tx_valid_q, tx_valid_n;
    logic [7:0]       tx_data_q, tx_data_n;
    logic             halt_q, halt_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;

    // Byte s (0 = most significant) of register r inside a flattened bank.
    function automatic logic [7:0] pick(input logic [TOTAL-1:0] v,
                                        input logic [RW-1:0]    r,
                                        input logic [SW-1:0]    s);
        int               base;
        logic [TOTAL-1:0] sh;
        base = int'(r) * BUS_SIZE + BUS_SIZE - 8 - 8 * int'(s);
        sh   = v >> base;
        return sh[7:0];
    endfunction

    always_comb begin
        state_n     = state;
        drain_cnt_n = drain_cnt;
        byte_cnt_n  = byte_cnt;
        reg_idx_n   = reg_idx;
        sub_idx_n   = sub_idx;
        tx_data_n   = tx_data_q;
        capture     = 1'b0;

        case (state)
            IDLE: begin
                if (i_start) begin
                    state_n     = DRAIN;
                    drain_cnt_n = DW'(DRAIN_CYCLES - 1);
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) state_n = SNAP;
                else                 drain_cnt_n = drain_cnt - DW'(1);
            end
            SNAP: begin
                // The first byte comes straight off the bus so it is valid on SEND entry.
                state_n    = SEND;
                capture    = 1'b1;
                byte_cnt_n = '0;
                reg_idx_n  = '0;
                sub_idx_n  = '0;
                tx_data_n  = pick(i_bus_debug, '0, '0);
            end
            SEND: begin
                if (tx_valid_q && i_tx_ready) begin
                    if (byte_cnt == CW'(NBYTES - 1)) begin
                        state_n = DONE;
                    end else begin
                        byte_cnt_n = byte_cnt + CW'(1);
                        if (sub_idx == SW'(BPR - 1)) begin
                            sub_idx_n = '0;
                            reg_idx_n = reg_idx + RW'(1);
                        end else begin
                            sub_idx_n = sub_idx + SW'(1);
                        end
                        tx_data_n = pick(shadow, reg_idx_n, sub_idx_n);
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register with it.
        halt_n     = (state_n == DRAIN) || (state_n == SNAP) || (state_n == SEND);
        busy_n     = (state_n != IDLE);
        tx_valid_n = (state_n == SEND);
        done_n     = (state_n == DONE);
        if (state_n != SEND) tx_data_n = '0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state      <= IDLE;
            drain_cnt  <= '0;
            byte_cnt   <= '0;
            reg_idx    <= '0;
            sub_idx    <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            halt_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_n;
            drain_cnt  <= drain_cnt_n;
            byte_cnt   <= byte_cnt_n;
            reg_idx    <= reg_idx_n;
            sub_idx    <= sub_idx_n;
            tx_valid_q <= tx_valid_n;
            tx_data_q  <= tx_data_n;
            halt_q     <= halt_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
        end
    end

    // Shadow needs no reset: it is only read after a capture.
    always_ff @(posedge i_clk) begin
        if (capture) shadow <= i_bus_debug;
    end

    assign o_tx_valid = tx_valid_q;
    assign o_tx_data  = tx_data_q;
    assign o_halt     = halt_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_regs_dump_ctrl.sv
// Directed bench for regs_dump_ctrl: reset, full dumps, backpressure,
// snapshot isolation, held start and mid-dump reset.
module tb_regs_dump_ctrl;

    localparam int R  = 32;
    localparam int B  = 32;
    localparam int D  = 4;
    localparam int NB = R * B / 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           tx_ready = 1'b1;
    logic [R*B-1:0] bus = '0;
    logic           tx_valid;
    logic [7:0]     tx_data;
    logic           halt;
    logic           busy;
    logic           done;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];

    int send_cycles, stalls, done_at;

    always #5 clk = ~clk;

    regs_dump_ctrl #(
        .REGISTERS_BANK_SIZE(R),
        .BUS_SIZE(B),
        .DRAIN_CYCLES(D)
    ) dut (
        .i_clk(clk),
        .i_reset(rst_n),
        .i_start(start),
        .i_bus_debug(bus),
        .i_tx_ready(tx_ready),
        .o_tx_valid(tx_valid),
        .o_tx_data(tx_data),
        .o_halt(halt),
        .o_busy(busy),
        .o_done(done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_pattern(input logic [31:0] base, input logic [31:0] stride);
        for (int k = 0; k < R; k++) bus[k*B +: B] = base + stride * k;
    endtask

    task automatic fill_exp();
        logic [31:0] word;
        exp_q.delete();
        for (int j = 0; j < NB; j++) begin
            word = bus[(j/4)*B +: B];
            exp_q.push_back(8'(word >> (24 - 8 * (j % 4))));
        end
    endtask

    // Samples i_start at the next edge, then walks the drain/snap window up to the first byte.
    task automatic start_dump(input bit keep);
        start = 1'b1;
        check("pre_halt", 32'(halt), 32'd0);
        step();
        if (!keep) start = 1'b0;
        check("halt_rise", 32'(halt), 32'd1);
        check("busy_rise", 32'(busy), 32'd1);
        check("drain_valid", 32'(tx_valid), 32'd0);
        for (int i = 2; i <= 5; i++) begin
            step();
            check("drain_halt", 32'(halt), 32'd1);
            check("drain_valid", 32'(tx_valid), 32'd0);
        end
        step();
        check("first_valid", 32'(tx_valid), 32'd1);
    endtask

    // Consumes bytes until the done pulse; stops in the done cycle.
    task automatic collect(input bit rnd, output int n_send, output int n_stall, output int at);
        logic [7:0] held;
        bit was_stall;
        bit finished;
        held = 8'h00;
        was_stall = 1'b0;
        finished = 1'b0;
        n_send = 0;
        n_stall = 0;
        at = -1;
        rx_q.delete();
        for (int c = 0; c < 1000 && !finished; c++) begin
            if (tx_valid) begin
                n_send++;
                if (was_stall) check("hold_data", 32'(tx_data), 32'(held));
                tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (tx_ready) begin
                    rx_q.push_back(tx_data);
                    if (exp_q.size() > 0) check("byte", 32'(tx_data), 32'(exp_q.pop_front()));
                    else                  check("extra_byte", 32'(rx_q.size()), 32'(NB));
                    was_stall = 1'b0;
                end else begin
                    n_stall++;
                    was_stall = 1'b1;
                    held = tx_data;
                end
            end else if (done) begin
                at = c;
                finished = 1'b1;
                check("done_halt", 32'(halt), 32'd0);
                check("done_busy", 32'(busy), 32'd1);
            end else begin
                check("bubble_valid", 32'(tx_valid), 32'd1);
            end
            if (!finished) step();
        end
        tx_ready = 1'b1;
        check("done_seen", 32'(finished), 32'd1);
        check("byte_count", 32'(rx_q.size()), 32'(NB));
        check("send_cycles", 32'(n_send), 32'(NB + n_stall));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_halt", 32'(halt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        step();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_halt", 32'(halt), 32'd0);

        // Full dump, ready held high
        load_pattern(32'hA000_0000, 32'd1);
        fill_exp();
        start_dump(1'b0);
        check("first_byte_now", 32'(tx_data), 32'hA0);
        collect(1'b0, send_cycles, stalls, done_at);
        check("done_offset", 32'(6 + done_at), 32'd134);
        check("no_stalls", 32'(stalls), 32'd0);
        if (rx_q.size() == NB) begin
            check("b0", 32'(rx_q[0]), 32'hA0);
            check("b1", 32'(rx_q[1]), 32'h00);
            check("b2", 32'(rx_q[2]), 32'h00);
            check("b3", 32'(rx_q[3]), 32'h00);
            check("b4", 32'(rx_q[4]), 32'hA0);
            check("b7", 32'(rx_q[7]), 32'h01);
            check("b127", 32'(rx_q[127]), 32'h1F);
        end
        step();
        check("done_once", 32'(done), 32'd0);
        check("back_idle", 32'(busy), 32'd0);

        // Backpressure with a random ready pattern
        fill_exp();
        start_dump(1'b0);
        collect(1'b1, send_cycles, stalls, done_at);
        check("bp_done_at", 32'(done_at), 32'(NB + stalls));
        check("bp_stalled", 32'(stalls > 0), 32'd1);
        step();

        // Snapshot isolation: bus overwritten in the cycle after SNAP
        load_pattern(32'h3C00_0000, 32'h0001_0203);
        fill_exp();
        start_dump(1'b0);
        bus = '1;
        check("snap_first", 32'(tx_data), 32'h3C);
        collect(1'b0, send_cycles, stalls, done_at);
        step();

        // Held start: ignored during SEND, new dump after returning to IDLE
        load_pattern(32'hA000_0000, 32'd1);
        fill_exp();
        start_dump(1'b1);
        collect(1'b0, send_cycles, stalls, done_at);
        check("held_done_offset", 32'(6 + done_at), 32'd134);
        step();
        check("held_idle_busy", 32'(busy), 32'd0);
        fill_exp();
        start_dump(1'b1);
        start = 1'b0;
        collect(1'b0, send_cycles, stalls, done_at);
        step();
        check("held_end_idle", 32'(busy), 32'd0);

        // Reset after the 10th byte
        fill_exp();
        start_dump(1'b0);
        for (int i = 0; i < 10; i++) begin
            tx_ready = 1'b1;
            check("pre_rst_byte", 32'(tx_data), 32'(exp_q.pop_front()));
            step();
        end
        check("pre_rst_valid", 32'(tx_valid), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("abort_valid", 32'(tx_valid), 32'd0);
        check("abort_halt", 32'(halt), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_abort_done", 32'(done), 32'd0);
            check("post_abort_busy", 32'(busy), 32'd0);
        end
        fill_exp();
        start_dump(1'b0);
        check("restart_byte0", 32'(tx_data), 32'hA0);
        collect(1'b0, send_cycles, stalls, done_at);
        check("restart_done_offset", 32'(6 + done_at), 32'd134);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regs_dump_ctrl.md
# regs_dump_ctrl

Debug sequencer that freezes the MIPS pipeline and streams the complete register bank contents out as bytes. On request it asserts a pipeline halt, waits a fixed drain period, snapshots the flattened register-bank debug bus, then serializes it over a valid/ready byte interface toward the debug UART transmitter. It releases the halt when the last byte has been accepted. It sits between the decode-stage debug bus, the pipeline stall/enable logic and the debug UART.

## Interface

Parameters:
- REGISTERS_BANK_SIZE, 32, number of architectural registers.
- BUS_SIZE, 32, register width in bits.
  - Must be a multiple of 8.
- DRAIN_CYCLES, 4, number of halted cycles before the snapshot.
  - Must be ≥ 1.

Ports:
- i_clk  in  1  clock; all logic is on the rising edge.
- i_reset  in  1  reset; synchronous, active-low.
- i_start  in  1  dump request; level-sampled, and only while in IDLE.
- i_bus_debug  in  REGISTERS_BANK_SIZE*BUS_SIZE  flattened register bank; register k is at [k*BUS_SIZE +: BUS_SIZE].
- i_tx_ready  in  1  byte sink ready.
- o_tx_valid  out  1  byte valid.
- o_tx_data  out  8  byte payload.
- o_halt  out  1  pipeline freeze request.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse when the dump completes.

## Operation

- All outputs are registered. When i_reset=0 at an edge, all outputs are 0 and the state is IDLE.

States:
- **IDLE**
  - Outputs are 0.
  - i_start=1 at an edge → DRAIN.
- **DRAIN**
  - o_halt=1, o_busy=1.
  - A down-counter is loaded with DRAIN_CYCLES−1.
  - When the counter reaches 0 → SNAP.
- **SNAP**
  - o_halt=1.
  - At the exit edge, i_bus_debug is copied into an internal shadow register.
  - → SEND.
- **SEND**
  - o_halt=1, o_tx_valid=1.
  - o_tx_data = the current byte of the shadow register.
  - Byte order: register 0 first, ascending; within each register, most-significant byte first.
  - Byte index j runs from 0 to NBYTES−1, with NBYTES = REGISTERS_BANK_SIZE*BUS_SIZE/8 (128 with the defaults).
  - Byte j is bits [(j/(BUS_SIZE/8))*BUS_SIZE + BUS_SIZE−8−8*(j mod (BUS_SIZE/8)) +: 8] of the shadow.
  - When the last byte is transferred → DONE.
- **DONE**
  - o_done=1, o_busy=1, o_halt=0, o_tx_valid=0, for exactly one cycle.
  - → IDLE.

Handshake:
- A transfer occurs at an edge where o_tx_valid=1 and i_tx_ready=1.
- o_tx_valid never depends combinationally on i_tx_ready.
- While valid is high and ready is low, o_tx_data is held stable.
- After a transfer that is not the last, the next byte is presented in the following cycle with valid still 1. There are no bubbles.

Boundary conditions:
- i_start is ignored in every state except IDLE.
- If i_start is still 1 when the block returns to IDLE, a new dump starts at the next edge.
- Changes on i_bus_debug after the snapshot do not affect the transmitted data.
- Reset during any state aborts immediately: halt and valid drop at the reset edge, and no o_done is generated.
- The byte counter and register index wrap to 0 only on entry to SEND.

## Timing

- Let the edge where i_start=1 is sampled in IDLE be edge E.
- From cycle E+1: o_halt=1 and o_busy=1, for DRAIN_CYCLES cycles of DRAIN.
- SNAP occupies cycle E+1+DRAIN_CYCLES. i_bus_debug is captured at the end of that cycle.
- First o_tx_valid=1: cycle E+2+DRAIN_CYCLES.
- With i_tx_ready held at 1:
  - the last byte is transferred at the end of cycle E+1+DRAIN_CYCLES+NBYTES;
  - o_done is high in cycle E+2+DRAIN_CYCLES+NBYTES;
  - the block is in IDLE the cycle after.
- Each cycle with i_tx_ready=0 while valid is high adds exactly one cycle to the SEND duration.

## Test plan

- **Reset values:** hold i_reset=0 for 3 cycles → all outputs 0. Release it → IDLE, with o_busy=0.
- **Full dump, defaults, ready=1:** register k = 0xA0000000 + k; pulse i_start.
  - o_halt rises 1 cycle later.
  - First byte 0xA0 appears at offset 6, followed by 0x00, 0x00, 0x00, 0xA0, 0x00, 0x00, 0x01, …, ending with 0x1F.
  - Exactly 128 bytes are sent.
  - o_done pulses once at offset 134; o_halt is 0 in that same cycle.
- **Backpressure:** drive i_tx_ready with a pseudo-random 50% pattern.
  - o_tx_data stays stable whenever valid=1 and ready=0.
  - The byte sequence is identical to the full-dump case.
  - Total SEND cycles = 128 + number of stall cycles.
- **Snapshot isolation:** change all registers to 0xFFFFFFFF one cycle after SNAP → the transmitted bytes still equal the pre-change values.
- **Ignored and held start:** pulse i_start during SEND → no effect. Hold i_start=1 continuously → a second dump begins the cycle after DONE.
- **Reset mid-operation:** assert i_reset=0 after the 10th byte has been transferred.
  - Next cycle: o_tx_valid=0, o_halt=0, o_busy=0.
  - No o_done is generated.
  - A subsequent i_start produces a full dump starting again from byte 0.
